// File: rtl/fmul_mant_post_norm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmul_mant_post_norm_if                                                |
// | Operand/result handshake bundle for the FP multiply post-normalizer.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface fmul_mant_post_norm_if;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  exp_10_i;
  logic [23:0] fracta_24_i;
  logic [23:0] fractb_24_i;
  logic        sign_i;
  logic [1:0]  exp_ovf_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        ovf_o;
  logic        unf_o;

  modport master (
    output valid_i, exp_10_i, fracta_24_i, fractb_24_i, sign_i, exp_ovf_i, ready_i,
    input  ready_o, valid_o, result_o, ovf_o, unf_o
  );

  modport slave (
    input  valid_i, exp_10_i, fracta_24_i, fractb_24_i, sign_i, exp_ovf_i, ready_i,
    output ready_o, valid_o, result_o, ovf_o, unf_o
  );
endinterface
`default_nettype wire

// File: rtl/fmul_mant_post_norm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmul_mant_post_norm                                                   |
// | Iterative mantissa multiply, normalize, round and pack to IEEE single.|
// | Optional macro FMUL_RADIX4_EN: two multiplier bits per MUL cycle.     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module fmul_mant_post_norm #(
  parameter int TRUNC = 0
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n_i,
  fmul_mant_post_norm_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

`ifdef FMUL_RADIX4_EN
  localparam logic [4:0] C_LAST_ITER = 5'd11;
`else
  localparam logic [4:0] C_LAST_ITER = 5'd23;
`endif

  logic [1:0]  r_state;
  logic [47:0] r_acc;
  logic [47:0] r_mcand;
  logic [23:0] r_mplr;
  logic [4:0]  r_cnt;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [1:0]  r_exp_ovf;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;
  logic        r_valid;

  logic [47:0] w_addend;
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic [23:0] w_mant_rnd;
  logic [8:0]  w_e_norm;
  logic [8:0]  w_e_rnd;
  logic [31:0] w_result;
  logic        w_ovf;
  logic        w_unf;

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
  assign bus.ovf_o    = r_ovf;
  assign bus.unf_o    = r_unf;

`ifdef FMUL_RADIX4_EN
  always_comb begin
    w_addend = '0;
    case (r_mplr[1:0])
      2'd1:    w_addend = r_mcand;
      2'd2:    w_addend = r_mcand << 1;
      2'd3:    w_addend = (r_mcand << 1) + r_mcand;
      default: w_addend = '0;
    endcase
  end
`else
  assign w_addend = r_mplr[0] ? r_mcand : 48'd0;
`endif

  // Normalization picks the leading one at P[47] or P[46]; rounding carry-out
  // leaves the mantissa field at zero and bumps the exponent instead.
  always_comb begin
    w_e_norm = {1'b0, r_exp};
    w_mant   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (r_acc[47]) begin
      w_mant   = r_acc[46:24];
      w_guard  = r_acc[23];
      w_sticky = |r_acc[22:0];
      w_e_norm = {1'b0, r_exp} + 9'd1;
    end else begin
      w_mant   = r_acc[45:23];
      w_guard  = r_acc[22];
      w_sticky = |r_acc[21:0];
    end
    w_inc      = (TRUNC == 0) && w_guard && (w_sticky || w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {23'd0, w_inc};
    w_e_rnd    = w_mant_rnd[23] ? (w_e_norm + 9'd1) : w_e_norm;

    w_result = '0;
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_exp_ovf[1] && r_exp_ovf[0]) begin
      w_result = {r_sign, 8'hFF, 23'h0};
      w_ovf    = 1'b1;
    end else if (r_exp_ovf[1]) begin
      w_result = {r_sign, 31'h0};
      w_unf    = 1'b1;
    end else if (r_acc[47:46] == 2'b00) begin
      w_result = {r_sign, 31'h0};
      w_unf    = (r_acc != 48'd0);
    end else if (w_e_rnd >= 9'd255) begin
      w_result = {r_sign, 8'hFF, 23'h0};
      w_ovf    = 1'b1;
    end else if (w_e_rnd == 9'd0) begin
      w_result = {r_sign, 31'h0};
      w_unf    = 1'b1;
    end else begin
      w_result = {r_sign, w_e_rnd[7:0], w_mant_rnd[22:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_exp_ovf <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            r_acc     <= '0;
            r_mcand   <= {24'd0, bus.fracta_24_i};
            r_mplr    <= bus.fractb_24_i;
            r_cnt     <= '0;
            r_exp     <= bus.exp_10_i;
            r_sign    <= bus.sign_i;
            r_exp_ovf <= bus.exp_ovf_i;
            r_state   <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= r_acc + w_addend;
`ifdef FMUL_RADIX4_EN
          r_mplr  <= r_mplr >> 2;
          r_mcand <= r_mcand << 2;
`else
          r_mplr  <= r_mplr >> 1;
          r_mcand <= r_mcand << 1;
`endif
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_valid  <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
